sumsq_stream_accum: RTL and testbench
=====================================

Name: sumsq_stream_accum

Overview:
- Streaming, pipelined sum-of-squares engine and next generation of the team's combinational 8×8-bit sum-of-squares block.
- Generalised in lane count, element width and accumulator width; adds a per-beat signed/unsigned mode.
- Accumulates squared lane values over a multi-beat vector delimited by in_last, with valid/ready flow control on both sides.
- Saturates and flags the result on accumulator overflow.
- Sits between the vector data source and downstream norm/energy consumers.

Parameters:
- N_LANES, 8, elements per input beat (≥1).
- ELEM_W, 8, bits per element (≥2).
- ACC_W, 32, accumulator/result width; must be ≥ 2*ELEM_W + clog2(N_LANES).
- CNT_W, 16, beat counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  N_LANES*ELEM_W  lane i = in_data[i*ELEM_W +: ELEM_W].
- in_signed  in  1  1 = lanes are two's complement, 0 = unsigned; sampled with each beat.
- in_last  in  1  final beat of the current vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  sum of squares over the vector (saturated).
- out_overflow  out  1  accumulation exceeded 2^ACC_W−1 for this vector.
- out_beats  out  CNT_W  beats in the vector (saturates at all-ones).

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n); all state clears on assertion; deassertion is synchronous to clk.
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_overflow=0, out_beats=0. Accumulator, counter, sticky flag and stage-1 valid are all 0.
- Beat transfer: in_valid && in_ready. Result transfer: out_valid && out_ready.
- Stage 1 (register P), on a transfer:
  - square each lane, ELEM_W-bit operand → 2*ELEM_W-bit unsigned square;
  - sign-extend when in_signed=1, zero-extend when 0 (e.g. 8-bit 0x80 signed → 16384, unsigned → 16384; 0xFF signed → 1, unsigned → 65025);
  - sum all lanes into p_sum, width 2*ELEM_W+clog2(N_LANES);
  - register p_sum, p_last and p_valid.
- Stage 2 consume condition: p_consume = p_valid && (!p_last || !out_valid || out_ready).
- On p_consume, form nxt = acc + p_sum at ACC_W+1 bits.
  - Overflow when bit ACC_W is set or the sticky flag is already set.
  - Beat counter increments and saturates at 2^CNT_W−1.
- If p_last=0 at consume:
  - acc ← nxt, saturated to all-ones on overflow;
  - sticky ← overflow;
  - count ← count+1.
- If p_last=1 at consume:
  - out_sum ← saturated nxt, out_overflow ← overflow, out_beats ← count+1, out_valid ← 1;
  - acc, sticky and count clear to 0 in the same cycle.
- A result transfer with no new result loading clears out_valid. A simultaneous result transfer and new result load keeps out_valid=1 and loads the new values.
- in_ready = !p_valid || p_consume. This is combinational from out_ready; no combinational path exists from in_valid.
- Latency: a last beat accepted at cycle t gives out_valid at t+2 with no stall. Full throughput is one beat per cycle.
- Single-beat vectors (in_valid && in_last) are legal and yield out_beats=1.
- out_* hold stable while out_valid && !out_ready.
- Backpressure: a pending last beat in P stalls while the output is occupied, and in_ready drops. Non-last beats of the next vector still accumulate while the previous result is held.
- in_data, in_signed and in_last are ignored when no transfer occurs.
- Reset mid-vector discards the partial accumulation and any held result. No spurious out_valid follows reset.

Test Plan:
- Defaults, 1 beat, in_signed=1, all lanes 0x80, in_last=1 → out_sum=131072 (0x20000), out_beats=1, out_overflow=0, out_valid two cycles after acceptance.
- Defaults, 1 beat, all lanes 0xFF: in_signed=0 → out_sum=520200; in_signed=1 → out_sum=8.
- 3 back-to-back beats of all lanes 0x01 (last on third), followed at once by a 1-beat vector of 0x02 → out_sum=24 with out_beats=3, then out_sum=32 with out_beats=1. in_ready stays 1 throughout.
- out_ready held low for 5 cycles while 2 single-beat vectors are sent → first result stable, in_ready drops with the second last beat pending, second result appears one cycle after out_ready rises; neither result is lost or duplicated.
- ACC_W=20, unsigned, 3 beats of all lanes 0xFF → out_sum=0xFFFFF, out_overflow=1. The next vector (1 beat of 0x01) → out_sum=8, out_overflow=0 (sticky cleared).
- rst_n pulsed low after 2 non-last beats, then a 1-beat vector of 0x03 → out_sum=72, out_beats=1, and no out_valid occurs during or just after reset.

Source files
------------

// File: rtl/sumsq_stream_accum.sv
// Streaming sum-of-squares accumulator: stage 1 squares and sums the lanes of a beat,
// stage 2 accumulates beats until in_last and presents a saturated per-vector result.
module sumsq_stream_accum #(
    parameter int N_LANES = 8,
    parameter int ELEM_W  = 8,
    parameter int ACC_W   = 32,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_LANES*ELEM_W-1:0] in_data,
    input  logic                      in_signed,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_sum,
    output logic                      out_overflow,
    output logic [CNT_W-1:0]          out_beats
);

    localparam int SQ_W   = 2 * ELEM_W;
    localparam int PSUM_W = SQ_W + $clog2(N_LANES);

    // Two guard bits make the signed product of the extended operand exact; the square
    // itself always fits in SQ_W unsigned bits.
    function automatic logic [SQ_W-1:0] square_lane(input logic [ELEM_W-1:0] e,
                                                    input logic            sgn);
        logic signed [SQ_W+1:0] x;
        logic signed [SQ_W+1:0] sq;
        x  = signed'({{(ELEM_W+2){sgn & e[ELEM_W-1]}}, e});
        sq = x * x;
        return sq[SQ_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W:0] v, input logic ovf);
        return ovf ? {ACC_W{1'b1}} : v[ACC_W-1:0];
    endfunction

    logic              p_valid_q, p_last_q;
    logic [PSUM_W-1:0] p_sum_q, p_sum_d;
    logic [ACC_W-1:0]  acc_q;
    logic              sticky_q;
    logic [CNT_W-1:0]  cnt_q, cnt_inc_d;
    logic [ACC_W:0]    nxt_d;
    logic              ovf_d;
    logic              p_consume;
    logic              out_valid_q, out_overflow_q;
    logic [ACC_W-1:0]  out_sum_q;
    logic [CNT_W-1:0]  out_beats_q;

    always_comb begin
        p_sum_d = '0;
        for (int i = 0; i < N_LANES; i++) begin
            p_sum_d = p_sum_d + PSUM_W'(square_lane(in_data[i*ELEM_W +: ELEM_W], in_signed));
        end
    end

    // A held last beat may only retire once the output register is free or draining.
    assign p_consume = p_valid_q && (!p_last_q || !out_valid_q || out_ready);
    assign in_ready  = !p_valid_q || p_consume;

    assign nxt_d     = {1'b0, acc_q} + (ACC_W+1)'(p_sum_q);
    assign ovf_d     = nxt_d[ACC_W] | sticky_q;
    assign cnt_inc_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_q      <= 1'b0;
            p_last_q       <= 1'b0;
            p_sum_q        <= '0;
            acc_q          <= '0;
            sticky_q       <= 1'b0;
            cnt_q          <= '0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_overflow_q <= 1'b0;
            out_beats_q    <= '0;
        end else begin
            if (in_ready) begin
                p_valid_q <= in_valid;
                if (in_valid) begin
                    p_sum_q  <= p_sum_d;
                    p_last_q <= in_last;
                end
            end

            if (p_consume && !p_last_q) begin
                acc_q    <= saturate(nxt_d, ovf_d);
                sticky_q <= ovf_d;
                cnt_q    <= cnt_inc_d;
            end else if (p_consume && p_last_q) begin
                acc_q    <= '0;
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end

            if (p_consume && p_last_q) begin
                out_valid_q    <= 1'b1;
                out_sum_q      <= saturate(nxt_d, ovf_d);
                out_overflow_q <= ovf_d;
                out_beats_q    <= cnt_inc_d;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_overflow = out_overflow_q;
    assign out_beats    = out_beats_q;

endmodule

// File: tb/tb_sumsq_stream_accum.sv
// Directed bench for sumsq_stream_accum: a default instance plus an ACC_W=20 instance
// used to exercise accumulator saturation.
module tb_sumsq_stream_accum;

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
        logic [15:0] beats;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_signed, in_last, out_valid, out_ready, out_overflow;
    logic [63:0] in_data;
    logic [31:0] out_sum;
    logic [15:0] out_beats;
    logic        b_in_valid, b_in_ready, b_in_signed, b_in_last, b_out_valid, b_out_ready;
    logic        b_out_overflow;
    logic [63:0] b_in_data;
    logic [19:0] b_out_sum;
    logic [15:0] b_out_beats;

    int errors = 0;
    int checks = 0;
    res_t qa[$];
    res_t qb[$];

    always #5 clk = ~clk;

    sumsq_stream_accum u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_signed(in_signed), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_overflow(out_overflow), .out_beats(out_beats)
    );

    sumsq_stream_accum #(.ACC_W(20)) u_dut20 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_signed(b_in_signed), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
        .out_overflow(b_out_overflow), .out_beats(b_out_beats)
    );

    // Record every result transfer; the next posedge completes it.
    always @(negedge clk) begin
        if (out_valid && out_ready)
            qa.push_back('{out_sum, out_overflow, out_beats});
        if (b_out_valid && b_out_ready)
            qb.push_back('{32'(b_out_sum), b_out_overflow, b_out_beats});
    end

    // Called and returning at posedge+1; holds the beat until it is accepted.
    task automatic send(input bit sel, input logic [7:0] b, input logic sg,
                        input logic lst, output int stalls);
        logic ok;
        ok = 1'b0;
        stalls = 0;
        if (sel) begin
            b_in_valid = 1'b1; b_in_data = {8{b}}; b_in_signed = sg; b_in_last = lst;
        end else begin
            in_valid = 1'b1; in_data = {8{b}}; in_signed = sg; in_last = lst;
        end
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = sel ? b_in_ready : in_ready;
            @(posedge clk);
            #1;
            if (!ok) stalls++;
        end
        in_valid = 1'b0;
        b_in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: beat %h not accepted, in_ready stayed %b", b, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_data = '0; in_signed = 0; in_last = 0; out_ready = 1;
        b_in_valid = 0; b_in_data = '0; b_in_signed = 0; b_in_last = 0; b_out_ready = 1;
        #2;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_sum !== 32'd0) begin errors++; $display("FAIL rst_out_sum: got %0d want 0", out_sum); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL rst_out_overflow: got %b want 0", out_overflow); end
        checks++; if (out_beats !== 16'd0) begin errors++; $display("FAIL rst_out_beats: got %0d want 0", out_beats); end
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ctrl: got valid=%b ready=%b want 0/1", b_out_valid, b_in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_latency();
        int st;
        qa.delete();
        send(0, 8'h80, 1'b1, 1'b1, st);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: out_valid got %b want 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: out_valid got %b want 1", out_valid); end
        checks++; if (out_sum !== 32'd131072) begin errors++; $display("FAIL lat_sum80: got %0d want 131072", out_sum); end
        checks++; if (out_beats !== 16'd1 || out_overflow !== 1'b0) begin errors++; $display("FAIL lat_beats_ovf: got %0d/%b want 1/0", out_beats, out_overflow); end
        idle(3);
        checks++; if (qa.size() != 1) begin errors++; $display("FAIL lat_count: got %0d results want 1", qa.size()); end
    endtask

    task automatic test_ff_modes();
        int st;
        qa.delete();
        send(0, 8'hFF, 1'b0, 1'b1, st);
        send(0, 8'hFF, 1'b1, 1'b1, st);
        idle(4);
        checks++;
        if (qa.size() != 2) begin
            errors++; $display("FAIL ff_count: got %0d results want 2", qa.size());
        end else begin
            checks++; if (qa[0].sum !== 32'd520200) begin errors++; $display("FAIL ff_unsigned: got %0d want 520200", qa[0].sum); end
            checks++; if (qa[1].sum !== 32'd8) begin errors++; $display("FAIL ff_signed: got %0d want 8", qa[1].sum); end
        end
    endtask

    task automatic test_back_to_back();
        int st, total;
        qa.delete();
        total = 0;
        send(0, 8'h01, 1'b0, 1'b0, st); total += st;
        send(0, 8'h01, 1'b0, 1'b0, st); total += st;
        send(0, 8'h01, 1'b0, 1'b1, st); total += st;
        send(0, 8'h02, 1'b0, 1'b1, st); total += st;
        idle(4);
        checks++; if (total != 0) begin errors++; $display("FAIL b2b_stalls: got %0d stalls want 0", total); end
        checks++;
        if (qa.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d results want 2", qa.size());
        end else begin
            checks++; if (qa[0].sum !== 32'd24 || qa[0].beats !== 16'd3) begin errors++; $display("FAIL b2b_first: got %0d/%0d want 24/3", qa[0].sum, qa[0].beats); end
            checks++; if (qa[1].sum !== 32'd32 || qa[1].beats !== 16'd1) begin errors++; $display("FAIL b2b_second: got %0d/%0d want 32/1", qa[1].sum, qa[1].beats); end
        end
    endtask

    task automatic test_backpressure();
        int st, total;
        qa.delete();
        total = 0;
        out_ready = 1'b0;
        send(0, 8'h01, 1'b0, 1'b1, st); total += st;
        send(0, 8'h02, 1'b0, 1'b1, st); total += st;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_sum !== 32'd8) begin errors++; $display("FAIL bp_first: got valid=%b sum=%0d want 1/8", out_valid, out_sum); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_sum !== 32'd8 || out_beats !== 16'd1) begin errors++; $display("FAIL bp_hold%0d: got valid=%b sum=%0d want 1/8", i, out_valid, out_sum); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_sum !== 32'd8) begin errors++; $display("FAIL bp_release: got %0d want 8", out_sum); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 32'd32) begin errors++; $display("FAIL bp_second: got valid=%b sum=%0d want 1/32", out_valid, out_sum); end
        idle(3);
        checks++; if (total != 0) begin errors++; $display("FAIL bp_send_stalls: got %0d want 0", total); end
        checks++;
        if (qa.size() != 2) begin
            errors++; $display("FAIL bp_count: got %0d results want 2", qa.size());
        end else begin
            checks++; if (qa[0].sum !== 32'd8 || qa[1].sum !== 32'd32) begin errors++; $display("FAIL bp_order: got %0d,%0d want 8,32", qa[0].sum, qa[1].sum); end
        end
    endtask

    task automatic test_overflow();
        int st;
        qb.delete();
        send(1, 8'hFF, 1'b0, 1'b0, st);
        send(1, 8'hFF, 1'b0, 1'b0, st);
        send(1, 8'hFF, 1'b0, 1'b1, st);
        send(1, 8'h01, 1'b0, 1'b1, st);
        idle(4);
        checks++;
        if (qb.size() != 2) begin
            errors++; $display("FAIL ovf_count: got %0d results want 2", qb.size());
        end else begin
            checks++; if (qb[0].sum !== 32'hFFFFF || qb[0].ovf !== 1'b1 || qb[0].beats !== 16'd3) begin errors++; $display("FAIL ovf_sat: got %h/%b/%0d want fffff/1/3", qb[0].sum, qb[0].ovf, qb[0].beats); end
            checks++; if (qb[1].sum !== 32'd8 || qb[1].ovf !== 1'b0) begin errors++; $display("FAIL ovf_sticky_clear: got %0d/%b want 8/0", qb[1].sum, qb[1].ovf); end
        end
    endtask

    task automatic test_reset_mid();
        int st;
        qa.delete();
        send(0, 8'h05, 1'b0, 1'b0, st);
        send(0, 8'h05, 1'b0, 1'b0, st);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_during: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_after%0d: out_valid got %b want 0", i, out_valid); end
        end
        @(posedge clk); #1;
        send(0, 8'h03, 1'b0, 1'b1, st);
        idle(4);
        checks++;
        if (qa.size() != 1) begin
            errors++; $display("FAIL rmid_count: got %0d results want 1", qa.size());
        end else begin
            checks++; if (qa[0].sum !== 32'd72 || qa[0].beats !== 16'd1) begin errors++; $display("FAIL rmid_result: got %0d/%0d want 72/1", qa[0].sum, qa[0].beats); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ff_modes();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
